// File: rtl/tank_rot_scan_pkg.sv
// Shared widths, FSM encoding and output saturation for the tank-rotation scheduler.
package tank_pkg;

    localparam int unsigned NTANK   = 2;
    localparam int unsigned COORD_W = 10;
    localparam int unsigned TRIG_W  = 8;
    localparam int unsigned FRAC    = 7;
    localparam int unsigned ACC_W   = 21;
    localparam int unsigned OUT_W   = 11;
    localparam int unsigned PROD_W  = OUT_W + TRIG_W;

    typedef enum logic [1:0] {IDLE, MUL, DRAIN, READY} rot_state_t;

    localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] OUT_MIN = ACC_W'(-(1 << (OUT_W - 1)));

    // Clamp an already-shifted accumulator value into the signed output range.
    function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] x);
        if (x > OUT_MAX) begin
            return OUT_MAX[OUT_W-1:0];
        end else if (x < OUT_MIN) begin
            return OUT_MIN[OUT_W-1:0];
        end else begin
            return x[OUT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/tank_rot_scan_rot_mul.sv
// Registered signed 11x8 -> 19-bit multiplier shared by all tanks.
module rot_mul
    import tank_pkg::*;
(
    input  logic                     clk,
    input  logic signed [OUT_W-1:0]  a,
    input  logic signed [TRIG_W-1:0] b,
    output logic signed [PROD_W-1:0] p
);

    always_ff @(posedge clk) begin
        p <= PROD_W'(a) * PROD_W'(b);
    end

endmodule

// File: rtl/tank_rot_scan.sv
// Per-scanline seed + incremental stepping of inverse-rotated sprite coordinates.
// Optional overrun flag and dropped-step counter: define TANK_ROT_OVERRUN_EN.
module tank_rot_scan
    import tank_pkg::*;
#(
    parameter int unsigned NTANK = tank_pkg::NTANK,
    parameter int unsigned FRAC  = tank_pkg::FRAC
) (
    input  logic                               Clk,
    input  logic                               Reset,
    input  logic                               line_start,
    input  logic [COORD_W-1:0]                 line_y,
    input  logic                               pix_step,
    input  logic [NTANK-1:0][COORD_W-1:0]      TankX,
    input  logic [NTANK-1:0][COORD_W-1:0]      TankY,
    input  logic [NTANK-1:0][TRIG_W-1:0]       tank_sin,
    input  logic [NTANK-1:0][TRIG_W-1:0]       tank_cos,
    output logic [NTANK-1:0][OUT_W-1:0]        rot_u,
    output logic [NTANK-1:0][OUT_W-1:0]        rot_v,
    output logic                               ready,
    output logic                               busy,
    output logic                               overrun
);

    localparam int unsigned NPROD = 4 * NTANK;
    localparam int unsigned KW    = $clog2(NPROD);
    localparam logic [KW-1:0] K_LAST = KW'(NPROD - 1);

    rot_state_t state_q, state_d;
    logic [KW-1:0] k_q, mul_k;
    logic          mul_vld;
    logic          step_ok;

    logic [COORD_W-1:0]              ly_q;
    logic [NTANK-1:0][COORD_W-1:0]   x_q, y_q;
    logic [NTANK-1:0][TRIG_W-1:0]    sin_q, cos_q;
    logic signed [ACC_W-1:0]         u_acc [NTANK];
    logic signed [ACC_W-1:0]         v_acc [NTANK];

    logic [COORD_W-1:0]        x_sel, y_sel;
    logic [TRIG_W-1:0]         s_sel, c_sel;
    logic signed [OUT_W-1:0]   xs, dy, op_a;
    logic signed [TRIG_W-1:0]  op_b;
    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W-1:0]   prod_ext;

    assign step_ok  = pix_step && !line_start && (state_q == READY);
    assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

    always_ff @(posedge Clk) begin
        if (!Reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (line_start) begin
            state_d = MUL;
        end else begin
            case (state_q)
                MUL:     if (k_q == K_LAST) state_d = DRAIN;
                DRAIN:   state_d = READY;
                default: state_d = state_q;
            endcase
        end
    end

    // k = 4*tank + j; j selects -X*cos, dy*sin (into u) and X*sin, dy*cos (into v).
    always_comb begin
        x_sel = '0;
        y_sel = '0;
        s_sel = '0;
        c_sel = '0;
        for (int unsigned i = 0; i < NTANK; i++) begin
            if (32'(k_q >> 2) == i) begin
                x_sel = x_q[i];
                y_sel = y_q[i];
                s_sel = sin_q[i];
                c_sel = cos_q[i];
            end
        end
        xs = {1'b0, x_sel};
        dy = {1'b0, ly_q} - {1'b0, y_sel};
        op_a = '0;
        op_b = '0;
        case (k_q[1:0])
            2'd0: begin op_a = -xs; op_b = c_sel; end
            2'd1: begin op_a = dy;  op_b = s_sel; end
            2'd2: begin op_a = xs;  op_b = s_sel; end
            default: begin op_a = dy; op_b = c_sel; end
        endcase
    end

    rot_mul u_mul (
        .clk (Clk),
        .a   (op_a),
        .b   (op_b),
        .p   (prod)
    );

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            k_q     <= '0;
            mul_k   <= '0;
            mul_vld <= 1'b0;
            ly_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            sin_q   <= '0;
            cos_q   <= '0;
            for (int unsigned i = 0; i < NTANK; i++) begin
                u_acc[i] <= '0;
                v_acc[i] <= '0;
            end
        end else begin
            mul_vld <= (state_q == MUL) && !line_start;
            mul_k   <= k_q;
            if (line_start) begin
                k_q   <= '0;
                ly_q  <= line_y;
                x_q   <= TankX;
                y_q   <= TankY;
                sin_q <= tank_sin;
                cos_q <= tank_cos;
                for (int unsigned i = 0; i < NTANK; i++) begin
                    u_acc[i] <= '0;
                    v_acc[i] <= '0;
                end
            end else begin
                if (state_q == MUL) k_q <= k_q + 1'b1;
                for (int unsigned i = 0; i < NTANK; i++) begin
                    if (mul_vld && (32'(mul_k >> 2) == i)) begin
                        if (!mul_k[1]) u_acc[i] <= u_acc[i] + prod_ext;
                        else           v_acc[i] <= v_acc[i] + prod_ext;
                    end else if (step_ok) begin
                        u_acc[i] <= u_acc[i] + {{(ACC_W - TRIG_W){cos_q[i][TRIG_W-1]}}, cos_q[i]};
                        v_acc[i] <= v_acc[i] - {{(ACC_W - TRIG_W){sin_q[i][TRIG_W-1]}}, sin_q[i]};
                    end
                end
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NTANK; i++) begin
            rot_u[i] = sat_out(u_acc[i] >>> FRAC);
            rot_v[i] = sat_out(v_acc[i] >>> FRAC);
        end
    end

    assign ready = (state_q == READY);
    assign busy  = (state_q == MUL) || (state_q == DRAIN);

`ifdef TANK_ROT_OVERRUN_EN
    logic       step_drop;
    logic       overrun_q;
    logic [7:0] drop_cnt;

    assign step_drop = pix_step && !line_start && (state_q != READY);

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            overrun_q <= 1'b0;
            drop_cnt  <= '0;
        end else if (step_drop) begin
            overrun_q <= 1'b1;
            if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_tank_rot_scan.sv
// Directed bench for tank_rot_scan with a scoreboard of expected coordinates.
module tb_tank_rot_scan;
    import tank_pkg::*;

    logic Clk = 1'b0;
    logic Reset, line_start, pix_step;
    logic [9:0] line_y;
    logic [1:0][9:0] TankX, TankY;
    logic [1:0][7:0] tank_sin, tank_cos;
    logic [1:0][10:0] rot_u, rot_v;
    logic ready, busy, overrun;

    int ncmp = 0;
    int nfail = 0;

    typedef struct {
        int id;
        int tank;
        int u;
        int v;
    } exp_t;
    exp_t sb[$];

    int sx[2], sy[2], ss[2], sc[2];
    int sly, nstep;

    tank_rot_scan #(.NTANK(2), .FRAC(7)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .line_start (line_start),
        .line_y     (line_y),
        .pix_step   (pix_step),
        .TankX      (TankX),
        .TankY      (TankY),
        .tank_sin   (tank_sin),
        .tank_cos   (tank_cos),
        .rot_u      (rot_u),
        .rot_v      (rot_v),
        .ready      (ready),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic cmp(input string tag, input int obs, input int exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_tank(input int i, input int x, input int y, input int s, input int c);
        TankX[i]    = 10'(x);
        TankY[i]    = 10'(y);
        tank_sin[i] = 8'(s);
        tank_cos[i] = 8'(c);
    endtask

    task automatic pulse();
        for (int i = 0; i < 2; i++) begin
            sx[i] = int'(TankX[i]);
            sy[i] = int'(TankY[i]);
            ss[i] = int'($signed(tank_sin[i]));
            sc[i] = int'($signed(tank_cos[i]));
        end
        sly = int'(line_y);
        nstep = 0;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 1;
        while (!ready && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic steps(input int n);
        repeat (n) begin
            pix_step = 1'b1;
            tick();
            pix_step = 1'b0;
        end
        nstep += n;
    endtask

    function automatic int clampo(input int a);
        if (a > 1023) return 1023;
        if (a < -1024) return -1024;
        return a;
    endfunction

    task automatic push_exp(input int id);
        int ua, va;
        for (int i = 0; i < 2; i++) begin
            ua = -sx[i] * sc[i] + (sly - sy[i]) * ss[i] + nstep * sc[i];
            va = sx[i] * ss[i] + (sly - sy[i]) * sc[i] - nstep * ss[i];
            sb.push_back('{id, i, clampo(ua >>> 7), clampo(va >>> 7)});
        end
    endtask

    task automatic check_sb();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            cmp($sformatf("id%0d_u%0d", e.id, e.tank), int'($signed(rot_u[e.tank])), e.u);
            cmp($sformatf("id%0d_v%0d", e.id, e.tank), int'($signed(rot_v[e.tank])), e.v);
        end
    endtask

    initial begin
        int n;
        int pulses;

        Reset = 1'b0;
        line_start = 1'b0;
        pix_step = 1'b0;
        line_y = '0;
        set_tank(0, 0, 0, 0, 0);
        set_tank(1, 0, 0, 0, 0);
        repeat (3) tick();
        Reset = 1'b1;
        tick();
        cmp("rst_ready", int'(ready), 0);
        cmp("rst_busy", int'(busy), 0);
        cmp("rst_overrun", int'(overrun), 0);
        cmp("rst_u0", int'($signed(rot_u[0])), 0);
        cmp("rst_v1", int'($signed(rot_v[1])), 0);

        // reset held three cycles in the middle of seeding
        set_tank(0, 100, 50, 0, 127);
        set_tank(1, 200, 100, 127, 0);
        line_y = 10'd50;
        pulse();
        tick();
        tick();
        cmp("midmul_busy", int'(busy), 1);
        Reset = 1'b0;
        repeat (3) tick();
        cmp("midrst_state", int'(dut.state_q), int'(IDLE));
        cmp("midrst_busy", int'(busy), 0);
        cmp("midrst_u1", int'($signed(rot_u[1])), 0);
        Reset = 1'b1;
        pulses = 0;
        repeat (15) begin
            tick();
            if (ready) pulses++;
        end
        cmp("midrst_no_ready", pulses, 0);

        // line A: tank0 straight, tank1 rotated
        pulse();
        cmp("seedA_busy_c1", int'(busy), 1);
        wait_ready(n);
        cmp("seedA_latency", n, 10);
        cmp("seedA_busy_done", int'(busy), 0);
        push_exp(1);
        check_sb();
        steps(100);
        push_exp(2);
        check_sb();
        steps(10);
        push_exp(3);
        check_sb();

        // line B: pix_step coinciding with line_start is dropped silently
        line_y = 10'd110;
        pix_step = 1'b1;
        pulse();
        pix_step = 1'b0;
        cmp("seedB_ready_drop", int'(ready), 0);
        wait_ready(n);
        cmp("seedB_latency", n, 10);
        push_exp(4);
        check_sb();
        steps(200);
        push_exp(5);
        check_sb();
        cmp("seedB_no_overrun", int'(overrun), 0);

        // restart at cycle 5 with a new TankX; later edits must not leak in
        set_tank(0, 300, 50, 0, 127);
        pulse();
        repeat (4) tick();
        set_tank(0, 40, 50, 0, 127);
        pulse();
        set_tank(0, 700, 50, 0, 127);
        wait_ready(n);
        cmp("restart_latency", n + 5, 15);
        push_exp(6);
        check_sb();

        // pix_step during seeding
        pulse();
        tick();
        tick();
        pix_step = 1'b1;
        tick();
        pix_step = 1'b0;
        wait_ready(n);
        cmp("drop_latency", n + 3, 10);
        push_exp(7);
        check_sb();
`ifdef TANK_ROT_OVERRUN_EN
        cmp("overrun_set", int'(overrun), 1);
        cmp("drop_cnt", int'(dut.drop_cnt), 1);
`else
        cmp("overrun_off", int'(overrun), 0);
`endif

        // extreme operands and saturation
        line_y = 10'd0;
        set_tank(0, 1023, 1023, -128, 0);
        set_tank(1, 1023, 1023, -128, 127);
        pulse();
        wait_ready(n);
        push_exp(8);
        check_sb();
        steps(20);
        push_exp(9);
        check_sb();
        set_tank(0, 1023, 1023, -128, -128);
        pulse();
        wait_ready(n);
        cmp("sat_latency", n, 10);
        push_exp(10);
        check_sb();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
